mem_block_responder: RTL and testbench
======================================

MEM_BLOCK_RESPONDER -- requirements
Module: mem_block_responder

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 12; number of word-address bits backed by internal storage (2^ADDR_BITS x 32-bit words).
REQ-002 SHALL have parameter BLOCK_WORDS, default 4; words per block transfer, power of two, range 2..16.
REQ-003 SHALL have parameter READ_LATENCY, default 2; cycles from request acceptance to first read beat, range 1..8.
REQ-004 SHALL have port clock_i, input, 1, single clock; all logic on its rising edge.
REQ-005 SHALL have port reset_i, input, 1, asynchronous, active-high reset.
REQ-006 SHALL have port mem_req_i, input, 1, request strobe from the comm buffer.
REQ-007 SHALL have port mem_reqBlock_i, input, 1: 1 = block transfer of BLOCK_WORDS words; 0 = single word.
REQ-008 SHALL have port mem_clear_i, input, 1, synchronous abort of the current transaction.
REQ-009 SHALL have port mem_rw_i, input, 1: 1 = write, 0 = read.
REQ-010 SHALL have port mem_add_i, input, 24, word address.
REQ-011 SHALL have port mem_data_i, input, 32, write data beat.
REQ-012 SHALL have port mem_ready_o, output, 1, responder accepts a request (IDLE) or a write beat (WRITE).
REQ-013 SHALL have port mem_valid_o, output, 1, mem_data_o holds a valid read beat this cycle.
REQ-014 SHALL have port mem_data_o, output, 32, read data beat.
REQ-015 SHALL have port mem_done_o, output, 1, one-cycle pulse marking transaction completion.
REQ-016 SHALL have port exception_o, output, 1, sticky out-of-range address flag.

Function
REQ-017 SHALL implement states IDLE, WRITE, READ_WAIT, READ_BURST, DONE.
REQ-018 SHALL assert mem_ready_o in IDLE and WRITE only, and accept a request on a rising edge with mem_req_i=1, mem_ready_o=1, mem_clear_i=0 in IDLE.
REQ-019 SHALL, for block requests, use base address mem_add_i with the low log2(BLOCK_WORDS) bits forced to zero and transfer words base+0 .. base+BLOCK_WORDS-1 in order.
REQ-020 SHALL, for single-word requests, use mem_add_i unmodified and transfer exactly one word.
REQ-021 SHALL, on write acceptance, store mem_data_i of the accept cycle as beat 0, go to WRITE for the remaining beats (one per cycle while mem_ready_o=1 and mem_req_i=1), then go to DONE; a single-word write goes directly to DONE.
REQ-022 SHALL hold WRITE without advancing the beat counter on any cycle with mem_req_i=0.
REQ-023 SHALL, on read acceptance, spend READ_LATENCY-1 cycles in READ_WAIT, then drive mem_valid_o=1 for 1 (single) or BLOCK_WORDS (block) consecutive cycles in READ_BURST, then go to DONE.
REQ-024 SHALL, in DONE, assert mem_done_o for exactly one cycle and return to IDLE.
REQ-025 SHALL ignore mem_req_i outside IDLE; no queuing.
REQ-026 SHALL, on mem_clear_i=1 in any state, return to IDLE next cycle with mem_valid_o=0 and mem_done_o=0; no done pulse for the aborted transaction; writes already accepted remain stored.
REQ-027 SHALL give mem_clear_i priority over mem_req_i when both are asserted in the same cycle in IDLE.
REQ-028 SHALL set exception_o when an accepted request has any mem_add_i bit at or above ADDR_BITS set, truncate the address to ADDR_BITS, and complete the transaction normally.
REQ-029 SHALL clear exception_o only on reset or mem_clear_i.
REQ-030 SHALL use a beat counter that wraps to 0 after BLOCK_WORDS-1, with no carry into the base address.

Reset
REQ-031 SHALL, on reset_i=1, go to IDLE and drive mem_ready_o=0 while reset is held, mem_ready_o=1 in the first cycle after release, mem_valid_o=0, mem_done_o=0, mem_data_o=0, exception_o=0, and clear all counters.
REQ-032 SHALL abort any in-flight transaction on reset without a done pulse, and SHALL NOT clear storage contents on reset.

Structure
REQ-033 SHALL place the state enumeration and the default values of ADDR_BITS, BLOCK_WORDS and READ_LATENCY in the shared memory-interface package.
REQ-034 SHALL instantiate one sub-module, mem_block_responder_ram: single-port synchronous RAM, 32-bit wide, 2^ADDR_BITS deep, one-cycle read.

Verification
REQ-035 SHALL verify: single write 0xDEADBEEF to 0x000010, then single read of 0x000010 -> first mem_valid_o with data 0xDEADBEEF 2 cycles after acceptance, mem_done_o on the next cycle.
REQ-036 SHALL verify: block write at 0x000023 with data 0x11,0x22,0x33,0x44 -> block read at 0x000020 returns 0x11,0x22,0x33,0x44 on 4 consecutive valid cycles, then one done pulse.
REQ-037 SHALL verify: block write with mem_req_i dropped for 2 cycles after beat 1 -> all 4 words stored correctly, done 1 cycle after beat 3.
REQ-038 SHALL verify: mem_clear_i asserted on the 2nd beat of a block read -> mem_valid_o=0 next cycle, no done pulse, mem_ready_o=1.
REQ-039 SHALL verify: single read at 0x100005 -> exception_o=1, data from word 0x005, exception_o held until mem_clear_i.
REQ-040 SHALL verify: reset asserted during READ_WAIT -> all outputs at reset values immediately, mem_ready_o=1 after release, storage contents unchanged.

Source files
------------

// File: rtl/mem_block_responder_pkg.sv
// Shared memory-interface definitions for the block responder: responder
// state encoding and default geometry/latency.
package mem_block_responder_pkg;

   localparam int MBR_ADDR_BITS    = 12;
   localparam int MBR_BLOCK_WORDS  = 4;
   localparam int MBR_READ_LATENCY = 2;
   localparam int MBR_DATA_W       = 32;
   localparam int MBR_ADDR_W       = 24;

   typedef enum logic [2:0] {
      IDLE,
      WRITE,
      READ_WAIT,
      READ_BURST,
      DONE
   } mbr_state_e;

endpackage

// File: rtl/mem_block_responder_ram.sv
// Single-port synchronous RAM with a registered read; contents are never
// reset so stored words survive a responder reset.
module mem_block_responder_ram
   import mem_block_responder_pkg::*;
#(
   parameter int ADDR_BITS = MBR_ADDR_BITS
) (
   input  logic                  clk_sys,
   input  logic                  we,
   input  logic [ADDR_BITS-1:0]  addr,
   input  logic [MBR_DATA_W-1:0] wdata,
   output logic [MBR_DATA_W-1:0] rdata
);

   logic [MBR_DATA_W-1:0] mem [2**ADDR_BITS];

   always_ff @(posedge clk_sys) begin
      if (we) mem[addr] <= wdata;
      else    rdata     <= mem[addr];
   end

endmodule

// File: rtl/mem_block_responder.sv
// Memory responder serving single-word and block read/write requests from an
// internal RAM, with a fixed read latency and a sticky out-of-range flag.
//
// state      | meaning
// IDLE       | ready for a new request
// WRITE      | collecting the remaining beats of a block write
// READ_WAIT  | waiting out the read latency before the first beat
// READ_BURST | driving read beats on mem_data_o
// DONE       | one-cycle completion pulse
module mem_block_responder
   import mem_block_responder_pkg::*;
#(
   parameter int ADDR_BITS    = MBR_ADDR_BITS,
   parameter int BLOCK_WORDS  = MBR_BLOCK_WORDS,
   parameter int READ_LATENCY = MBR_READ_LATENCY
) (
   input  logic                  clock_i,
   input  logic                  reset_i,
   input  logic                  mem_req_i,
   input  logic                  mem_reqBlock_i,
   input  logic                  mem_clear_i,
   input  logic                  mem_rw_i,
   input  logic [MBR_ADDR_W-1:0] mem_add_i,
   input  logic [MBR_DATA_W-1:0] mem_data_i,
   output logic                  mem_ready_o,
   output logic                  mem_valid_o,
   output logic [MBR_DATA_W-1:0] mem_data_o,
   output logic                  mem_done_o,
   output logic                  exception_o
);

   localparam int              LB        = $clog2(BLOCK_WORDS);
   localparam logic [LB-1:0]   LAST_BEAT = LB'(BLOCK_WORDS - 1);
   localparam logic [LB-1:0]   BEAT_ONE  = LB'(1);
   localparam int              WAIT_W    = 4;
   localparam logic [WAIT_W-1:0] WAIT_LOAD =
      WAIT_W'((READ_LATENCY > 1) ? READ_LATENCY - 2 : 0);

   mbr_state_e            state, state_next;
   logic [ADDR_BITS-1:0]  base, req_base, ram_addr;
   logic [LB-1:0]         beat, beat_inc;
   logic [WAIT_W-1:0]     wait_cnt;
   logic                  block, exception;
   logic                  accept, out_of_range, final_beat, ram_we;
   logic [MBR_DATA_W-1:0] ram_rdata;

   assign accept       = (state == IDLE) && mem_req_i && !mem_clear_i;
   assign out_of_range = (mem_add_i >> ADDR_BITS) != '0;
   assign final_beat   = !block || (beat == LAST_BEAT);
   assign beat_inc     = beat + BEAT_ONE;
   assign exception_o  = exception;

   always_comb begin
      req_base = mem_add_i[ADDR_BITS-1:0];
      if (mem_reqBlock_i) req_base[LB-1:0] = '0;
   end

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) state <= IDLE;
      else         state <= state_next;
   end

   always_comb begin
      state_next = state;
      if (mem_clear_i) begin
         state_next = IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (mem_req_i) begin
                  if (mem_rw_i) state_next = mem_reqBlock_i ? WRITE : DONE;
                  else          state_next = (READ_LATENCY > 1) ? READ_WAIT : READ_BURST;
               end
            end
            WRITE:      if (mem_req_i && final_beat) state_next = DONE;
            READ_WAIT:  if (wait_cnt == '0) state_next = READ_BURST;
            READ_BURST: if (final_beat) state_next = DONE;
            DONE:       state_next = IDLE;
            default:    state_next = IDLE;
         endcase
      end
   end

   always_comb begin
      mem_ready_o = 1'b0;
      mem_valid_o = 1'b0;
      mem_done_o  = 1'b0;
      case (state)
         IDLE, WRITE: mem_ready_o = !reset_i;
         READ_BURST:  mem_valid_o = 1'b1;
         DONE:        mem_done_o  = 1'b1;
         default:     ;
      endcase
   end

   assign mem_data_o = mem_valid_o ? ram_rdata : '0;

   // Beat offsets stay inside the block: the low bits wrap without carrying
   // into the base. During a burst the RAM is already fetching the next beat.
   always_comb begin
      ram_we   = 1'b0;
      ram_addr = {base[ADDR_BITS-1:LB], base[LB-1:0] + beat};
      case (state)
         IDLE: begin
            ram_addr = req_base;
            ram_we   = accept && mem_rw_i;
         end
         WRITE:      ram_we   = mem_req_i && !mem_clear_i;
         READ_BURST: ram_addr = {base[ADDR_BITS-1:LB], base[LB-1:0] + beat_inc};
         default:    ;
      endcase
   end

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         base      <= '0;
         beat      <= '0;
         block     <= 1'b0;
         wait_cnt  <= '0;
         exception <= 1'b0;
      end else if (mem_clear_i) begin
         beat      <= '0;
         wait_cnt  <= '0;
         exception <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  base     <= req_base;
                  block    <= mem_reqBlock_i;
                  wait_cnt <= WAIT_LOAD;
                  beat     <= (mem_rw_i && mem_reqBlock_i) ? BEAT_ONE : '0;
                  if (out_of_range) exception <= 1'b1;
               end
            end
            WRITE:      if (mem_req_i) beat <= beat_inc;
            READ_WAIT:  if (wait_cnt != '0) wait_cnt <= wait_cnt - WAIT_W'(1);
            READ_BURST: beat <= beat_inc;
            default:    ;
         endcase
      end
   end

   mem_block_responder_ram #(
      .ADDR_BITS (ADDR_BITS)
   ) u_ram (
      .clk_sys (clock_i),
      .we      (ram_we),
      .addr    (ram_addr),
      .wdata   (mem_data_i),
      .rdata   (ram_rdata)
   );

endmodule

// File: tb/tb_mem_block_responder.sv
// Directed and randomized checks of mem_block_responder against an
// array-based memory model with cycle-exact handshake expectations.
module tb_mem_block_responder;

   localparam int AB = 12;
   localparam int BW = 4;
   localparam int RL = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        req, block, clear, rw;
   logic [23:0] addr;
   logic [31:0] wdata;
   logic        ready, valid, done, exc;
   logic [31:0] rdata;

   int          tests = 0;
   int          failures = 0;
   logic        exc_model = 1'b0;
   logic [31:0] ref_mem [2**AB];
   logic [31:0] wbuf [BW];

   always #5 clk = ~clk;

   mem_block_responder #(
      .ADDR_BITS    (AB),
      .BLOCK_WORDS  (BW),
      .READ_LATENCY (RL)
   ) dut (
      .clock_i        (clk),
      .reset_i        (rst),
      .mem_req_i      (req),
      .mem_reqBlock_i (block),
      .mem_clear_i    (clear),
      .mem_rw_i       (rw),
      .mem_add_i      (addr),
      .mem_data_i     (wdata),
      .mem_ready_o    (ready),
      .mem_valid_o    (valid),
      .mem_data_o     (rdata),
      .mem_done_o     (done),
      .exception_o    (exc)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Word index touched by beat i of a request, after block alignment and truncation.
   function automatic logic [AB-1:0] widx(input logic [23:0] a, input logic b, input int i);
      logic [23:0] w;
      w = b ? (a & ~24'(BW - 1)) : a;
      w = w + 24'(i);
      return w[AB-1:0];
   endfunction

   task automatic do_write(input logic t_block, input logic [23:0] t_addr,
                           input int gap_at, input int gap_len);
      int n;
      n = t_block ? BW : 1;
      check("wr_ready", ready, 1'b1);
      req = 1'b1; rw = 1'b1; block = t_block; addr = t_addr; wdata = wbuf[0];
      tick();
      ref_mem[widx(t_addr, t_block, 0)] = wbuf[0];
      if (t_addr[23:AB] != '0) exc_model = 1'b1;
      for (int i = 1; i < n; i++) begin
         if (i - 1 == gap_at) begin
            req = 1'b0;
            for (int g = 0; g < gap_len; g++) begin
               wdata = $urandom; addr = 24'($urandom);
               check("wr_gap_ready", ready, 1'b1);
               check("wr_gap_done", done, 1'b0);
               tick();
            end
         end
         req = 1'b1; wdata = wbuf[i]; addr = 24'($urandom);
         check("wr_beat_ready", ready, 1'b1);
         tick();
         ref_mem[widx(t_addr, t_block, i)] = wbuf[i];
      end
      req = 1'b0;
      check("wr_done", done, 1'b1);
      check("wr_done_valid", valid, 1'b0);
      tick();
      check("wr_done_once", done, 1'b0);
      check("wr_exc", exc, exc_model);
   endtask

   task automatic do_read(input logic t_block, input logic [23:0] t_addr, input int clear_at);
      int n;
      n = t_block ? BW : 1;
      check("rd_ready", ready, 1'b1);
      req = 1'b1; rw = 1'b0; block = t_block; addr = t_addr;
      tick();
      req = 1'b0; addr = 24'($urandom);
      if (t_addr[23:AB] != '0) exc_model = 1'b1;
      for (int c = 1; c < RL; c++) begin
         check("rd_wait_valid", valid, 1'b0);
         check("rd_wait_ready", ready, 1'b0);
         tick();
      end
      for (int i = 0; i < n; i++) begin
         check("rd_valid", valid, 1'b1);
         check("rd_data", rdata, ref_mem[widx(t_addr, t_block, i)]);
         if (i == clear_at) begin
            clear = 1'b1;
            tick();
            clear = 1'b0;
            exc_model = 1'b0;
            check("clr_valid", valid, 1'b0);
            check("clr_done", done, 1'b0);
            check("clr_ready", ready, 1'b1);
            tick();
            check("clr_no_late_done", done, 1'b0);
            return;
         end
         tick();
      end
      check("rd_done", done, 1'b1);
      check("rd_done_valid", valid, 1'b0);
      tick();
      check("rd_done_once", done, 1'b0);
      check("rd_exc", exc, exc_model);
   endtask

   // Clear in IDLE, optionally racing a single-word write that must be dropped.
   task automatic do_clear(input logic with_req);
      clear = 1'b1; req = with_req; rw = 1'b1; block = 1'b0;
      addr = 24'($urandom_range(0, 63)); wdata = $urandom;
      tick();
      clear = 1'b0; req = 1'b0;
      exc_model = 1'b0;
      check("idle_clr_done", done, 1'b0);
      check("idle_clr_ready", ready, 1'b1);
      check("idle_clr_exc", exc, 1'b0);
   endtask

   initial begin
      logic [23:0] a;
      int          g;
      rst = 1'b1; req = 1'b0; block = 1'b0; clear = 1'b0; rw = 1'b0;
      addr = '0; wdata = '0;
      tick();
      tick();
      check("rst_ready", ready, 1'b0);
      check("rst_valid", valid, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_data", rdata, 32'h0);
      check("rst_exc", exc, 1'b0);
      rst = 1'b0;
      #1;
      check("rel_ready", ready, 1'b1);

      // single write then single read
      wbuf[0] = 32'hDEADBEEF;
      do_write(1'b0, 24'h000010, -1, 0);
      do_read(1'b0, 24'h000010, -1);

      // block write at unaligned address, block read at aligned base
      wbuf[0] = 32'h11; wbuf[1] = 32'h22; wbuf[2] = 32'h33; wbuf[3] = 32'h44;
      do_write(1'b1, 24'h000023, -1, 0);
      do_read(1'b1, 24'h000020, -1);

      // block write with request dropped for two cycles after beat 1
      wbuf[0] = 32'hA0; wbuf[1] = 32'hA1; wbuf[2] = 32'hA2; wbuf[3] = 32'hA3;
      do_write(1'b1, 24'h000040, 1, 2);
      do_read(1'b1, 24'h000042, -1);

      // clear on the second beat of a block read
      do_read(1'b1, 24'h000020, 1);

      // out-of-range read is truncated and raises a sticky exception
      wbuf[0] = 32'hA5A50005;
      do_write(1'b0, 24'h000005, -1, 0);
      do_read(1'b0, 24'h100005, -1);
      check("exc_set", exc, 1'b1);
      do_read(1'b0, 24'h000010, -1);
      check("exc_held", exc, 1'b1);
      do_clear(1'b1);
      do_read(1'b0, 24'h000005, -1);

      // reset during READ_WAIT
      req = 1'b1; rw = 1'b0; block = 1'b0; addr = 24'hFFF010;
      tick();
      req = 1'b0;
      check("rw_exc_pre", exc, 1'b1);
      rst = 1'b1;
      #1;
      check("rw_rst_ready", ready, 1'b0);
      check("rw_rst_valid", valid, 1'b0);
      check("rw_rst_done", done, 1'b0);
      check("rw_rst_data", rdata, 32'h0);
      check("rw_rst_exc", exc, 1'b0);
      tick();
      check("rw_rst_hold_valid", valid, 1'b0);
      check("rw_rst_hold_ready", ready, 1'b0);
      rst = 1'b0;
      exc_model = 1'b0;
      #1;
      check("rw_rel_ready", ready, 1'b1);
      tick();
      check("rw_no_done", done, 1'b0);
      check("rw_no_valid", valid, 1'b0);
      do_read(1'b0, 24'h000010, -1);
      do_read(1'b1, 24'h000020, -1);

      // randomized traffic over a pre-filled window of 64 words
      for (int k = 0; k < 16; k++) begin
         for (int j = 0; j < BW; j++) wbuf[j] = $urandom;
         do_write(1'b1, 24'(k * BW), -1, 0);
      end
      for (int t = 0; t < 60; t++) begin
         a = 24'($urandom_range(0, 63));
         if ($urandom_range(0, 7) == 0) a[23:AB] = (24 - AB)'($urandom_range(1, 4095));
         case ($urandom_range(0, 4))
            0, 1: begin
               for (int j = 0; j < BW; j++) wbuf[j] = $urandom;
               g = $urandom_range(0, 3);
               do_write(1'($urandom_range(0, 1)), a, (g == 0) ? -1 : $urandom_range(0, BW - 2), g);
            end
            2, 3: do_read(1'($urandom_range(0, 1)), a, ($urandom_range(0, 5) == 0) ? $urandom_range(0, 1) : -1);
            default: do_clear(1'($urandom_range(0, 1)));
         endcase
         check("rnd_exc", exc, exc_model);
      end

      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end

endmodule
